// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor table write scheduler.
package bp_pkg;

  // Storage widths for queued updates; fields are zero-extended into these.
  localparam int BP_IDX_MAX  = 16;
  localparam int BP_HIST_MAX = 16;
  localparam int BP_TAG_MAX  = 30;

  // Counter value forced by pht_clear_o.
  localparam logic [1:0] PHT_WEAK_NT = 2'b01;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic                   btb_we;
    logic                   pht_we;
    logic [BP_IDX_MAX-1:0]  btb_index;
    logic [BP_TAG_MAX-1:0]  btb_tag;
    logic [31:0]            btb_target;
    logic [BP_HIST_MAX-1:0] pht_index;
    logic                   taken;
  } bp_upd_t;

endpackage

// File: rtl/bp_table_scheduler_if.sv
// Commit-stage update channel into the table scheduler.
interface bp_table_scheduler_if #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8
);
  logic                     upd_valid_i;
  logic                     upd_ready_o;
  logic                     upd_btb_we_i;
  logic                     upd_pht_we_i;
  logic [INDEX_WIDTH-1:0]   upd_btb_index_i;
  logic [29-INDEX_WIDTH:0]  upd_btb_tag_i;
  logic [31:0]              upd_btb_target_i;
  logic [HISTORY_WIDTH-1:0] upd_pht_index_i;
  logic                     upd_taken_i;

  modport master (
    output upd_valid_i, upd_btb_we_i, upd_pht_we_i, upd_btb_index_i,
           upd_btb_tag_i, upd_btb_target_i, upd_pht_index_i, upd_taken_i,
    input  upd_ready_o
  );

  modport slave (
    input  upd_valid_i, upd_btb_we_i, upd_pht_we_i, upd_btb_index_i,
           upd_btb_tag_i, upd_btb_target_i, upd_pht_index_i, upd_taken_i,
    output upd_ready_o
  );
endinterface

// File: rtl/bp_update_fifo.sv
// Small FIFO holding commit updates while the tables are being swept or drained.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  bp_upd_t data_i,
  input  logic    pop_i,
  output bp_upd_t data_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(QDEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  bp_upd_t     mem_q [QDEPTH];
  bp_upd_t     mem_d [QDEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; push is ignored when full, pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_table_scheduler.sv
// Owns the single BTB/PHT write ports: init/flush sweep versus commit updates.
module bp_table_scheduler
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8,
  parameter int QDEPTH        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_req_i,
  bp_table_scheduler_if.slave      upd_if,
  output logic                     btb_wr_en_o,
  output logic [INDEX_WIDTH-1:0]   btb_wr_index_o,
  output logic [29-INDEX_WIDTH:0]  btb_wr_tag_o,
  output logic [31:0]              btb_wr_target_o,
  output logic                     btb_wr_valid_o,
  output logic                     pht_wr_en_o,
  output logic [HISTORY_WIDTH-1:0] pht_wr_index_o,
  output logic                     pht_wr_taken_o,
  output logic                     pht_clear_o,
  output logic                     ghr_clear_o,
  output logic                     pred_enable_o,
  output logic                     flush_ack_o
);
  localparam int            SW          = (INDEX_WIDTH > HISTORY_WIDTH) ? INDEX_WIDTH : HISTORY_WIDTH;
  localparam int            TAG_W       = 30 - INDEX_WIDTH;
  localparam logic [SW:0]   SWEEP_LAST  = (SW+1)'((1 << SW) - 1);
  localparam logic [SW:0]   BTB_ENTRIES = (SW+1)'(1 << INDEX_WIDTH);
  localparam logic [SW:0]   PHT_ENTRIES = (SW+1)'(1 << HISTORY_WIDTH);

  bp_state_e state_q, state_d;
  logic [SW:0] ctr_q, ctr_d;

  logic                     btb_en_q, btb_en_d, btb_vld_q, btb_vld_d;
  logic [INDEX_WIDTH-1:0]   btb_idx_q, btb_idx_d;
  logic [TAG_W-1:0]         btb_tag_q, btb_tag_d;
  logic [31:0]              btb_tgt_q, btb_tgt_d;
  logic                     pht_en_q, pht_en_d, pht_tkn_q, pht_tkn_d, pht_clr_q, pht_clr_d;
  logic [HISTORY_WIDTH-1:0] pht_idx_q, pht_idx_d;
  logic                     ghr_clr_q, ghr_clr_d, ack_q, ack_d, pred_en_q, pred_en_d;

  bp_upd_t upd_in_s, fifo_head_s, sel_s;
  logic    full_s, empty_s, accept_s, run_s, bypass_s, push_s, pop_s;
  logic    unused_sel_s;

  // Zero-extend the incoming update into the queue record.
  always_comb begin
    upd_in_s            = '0;
    upd_in_s.btb_we     = upd_if.upd_btb_we_i;
    upd_in_s.pht_we     = upd_if.upd_pht_we_i;
    upd_in_s.btb_index  = BP_IDX_MAX'(upd_if.upd_btb_index_i);
    upd_in_s.btb_tag    = BP_TAG_MAX'(upd_if.upd_btb_tag_i);
    upd_in_s.btb_target = upd_if.upd_btb_target_i;
    upd_in_s.pht_index  = BP_HIST_MAX'(upd_if.upd_pht_index_i);
    upd_in_s.taken      = upd_if.upd_taken_i;
  end

  // A flush request suspends draining in the same cycle it arrives.
  assign run_s    = (state_q == RUN) && !flush_req_i;
  assign accept_s = upd_if.upd_valid_i && !full_s;
  assign bypass_s = run_s && empty_s && accept_s;
  assign push_s   = accept_s && !bypass_s;
  assign pop_s    = run_s && !empty_s;
  assign sel_s    = pop_s ? fifo_head_s : upd_in_s;
  assign unused_sel_s = ^sel_s;

  assign upd_if.upd_ready_o = !full_s;

  bp_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (upd_in_s),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // FSM, sweep counter and next value of the write-port register stage.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    btb_en_d  = 1'b0;
    btb_idx_d = '0;
    btb_tag_d = '0;
    btb_tgt_d = 32'h0;
    btb_vld_d = 1'b0;
    pht_en_d  = 1'b0;
    pht_idx_d = '0;
    pht_tkn_d = 1'b0;
    pht_clr_d = 1'b0;
    ghr_clr_d = 1'b0;
    ack_d     = 1'b0;
    pred_en_d = 1'b0;
    case (state_q)
      SWEEP: begin
        if (flush_req_i) begin
          // Abort: restart from entry 0 next cycle, no write this cycle.
          ctr_d = '0;
        end else begin
          ghr_clr_d = (ctr_q == '0);
          btb_en_d  = (ctr_q < BTB_ENTRIES);
          btb_idx_d = ctr_q[INDEX_WIDTH-1:0];
          pht_en_d  = (ctr_q < PHT_ENTRIES);
          pht_idx_d = ctr_q[HISTORY_WIDTH-1:0];
          pht_clr_d = (ctr_q < PHT_ENTRIES);
          if (ctr_q == SWEEP_LAST) begin
            ack_d     = 1'b1;
            pred_en_d = 1'b1;
            state_d   = RUN;
            ctr_d     = '0;
          end else begin
            ctr_d = ctr_q + (SW+1)'(1);
          end
        end
      end
      RUN: begin
        if (flush_req_i) begin
          state_d = SWEEP;
          ctr_d   = '0;
        end else begin
          pred_en_d = 1'b1;
          if (pop_s || bypass_s) begin
            btb_en_d  = sel_s.btb_we;
            btb_idx_d = sel_s.btb_index[INDEX_WIDTH-1:0];
            btb_tag_d = sel_s.btb_tag[TAG_W-1:0];
            btb_tgt_d = sel_s.btb_target;
            btb_vld_d = 1'b1;
            pht_en_d  = sel_s.pht_we;
            pht_idx_d = sel_s.pht_index[HISTORY_WIDTH-1:0];
            pht_tkn_d = sel_s.taken;
          end else begin
            btb_en_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = SWEEP;
        ctr_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset restarts the sweep with all outputs low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= SWEEP;
      ctr_q     <= '0;
      btb_en_q  <= 1'b0;
      btb_idx_q <= '0;
      btb_tag_q <= '0;
      btb_tgt_q <= 32'h0;
      btb_vld_q <= 1'b0;
      pht_en_q  <= 1'b0;
      pht_idx_q <= '0;
      pht_tkn_q <= 1'b0;
      pht_clr_q <= 1'b0;
      ghr_clr_q <= 1'b0;
      ack_q     <= 1'b0;
      pred_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      btb_en_q  <= btb_en_d;
      btb_idx_q <= btb_idx_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
      btb_vld_q <= btb_vld_d;
      pht_en_q  <= pht_en_d;
      pht_idx_q <= pht_idx_d;
      pht_tkn_q <= pht_tkn_d;
      pht_clr_q <= pht_clr_d;
      ghr_clr_q <= ghr_clr_d;
      ack_q     <= ack_d;
      pred_en_q <= pred_en_d;
    end
  end

  assign btb_wr_en_o     = btb_en_q;
  assign btb_wr_index_o  = btb_idx_q;
  assign btb_wr_tag_o    = btb_tag_q;
  assign btb_wr_target_o = btb_tgt_q;
  assign btb_wr_valid_o  = btb_vld_q;
  assign pht_wr_en_o     = pht_en_q;
  assign pht_wr_index_o  = pht_idx_q;
  assign pht_wr_taken_o  = pht_tkn_q;
  assign pht_clear_o     = pht_clr_q;
  assign ghr_clear_o     = ghr_clr_q;
  assign flush_ack_o     = ack_q;
  assign pred_enable_o   = pred_en_q;

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Directed bench for bp_table_scheduler (INDEX_WIDTH=4, HISTORY_WIDTH=6, QDEPTH=4).
module tb_bp_table_scheduler;
  logic clk_i = 1'b0;
  logic rst_ni, flush_req_i;
  logic btb_wr_en_o, btb_wr_valid_o, pht_wr_en_o, pht_wr_taken_o, pht_clear_o;
  logic ghr_clear_o, pred_enable_o, flush_ack_o;
  logic [3:0]  btb_wr_index_o;
  logic [25:0] btb_wr_tag_o;
  logic [31:0] btb_wr_target_o;
  logic [5:0]  pht_wr_index_o;
  int n_checks = 0;
  int n_fail   = 0;

  bp_table_scheduler_if #(.INDEX_WIDTH(4), .HISTORY_WIDTH(6)) upd_if ();

  bp_table_scheduler #(.INDEX_WIDTH(4), .HISTORY_WIDTH(6), .QDEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_req_i(flush_req_i), .upd_if(upd_if),
    .btb_wr_en_o(btb_wr_en_o), .btb_wr_index_o(btb_wr_index_o), .btb_wr_tag_o(btb_wr_tag_o),
    .btb_wr_target_o(btb_wr_target_o), .btb_wr_valid_o(btb_wr_valid_o),
    .pht_wr_en_o(pht_wr_en_o), .pht_wr_index_o(pht_wr_index_o), .pht_wr_taken_o(pht_wr_taken_o),
    .pht_clear_o(pht_clear_o), .ghr_clear_o(ghr_clear_o), .pred_enable_o(pred_enable_o),
    .flush_ack_o(flush_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic bwe, input logic pwe, input logic [3:0] bi,
                           input logic [25:0] tg, input logic [31:0] tt, input logic [5:0] pi,
                           input logic tk);
    upd_if.upd_valid_i      = v;
    upd_if.upd_btb_we_i     = bwe;
    upd_if.upd_pht_we_i     = pwe;
    upd_if.upd_btb_index_i  = bi;
    upd_if.upd_btb_tag_i    = tg;
    upd_if.upd_btb_target_i = tt;
    upd_if.upd_pht_index_i  = pi;
    upd_if.upd_taken_i      = tk;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    flush_req_i = 1'b0;
    drive_upd(1'b0, 1'b0, 1'b0, 4'h0, 26'h0, 32'h0, 6'h0, 1'b0);
    tick; tick; tick;
    n_checks++;
    if ({btb_wr_en_o, pht_wr_en_o, pht_clear_o, ghr_clear_o, flush_ack_o, pred_enable_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {btb_wr_en_o, pht_wr_en_o, pht_clear_o, ghr_clear_o, flush_ack_o, pred_enable_o});
    end
    n_checks++;
    if (upd_if.upd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", upd_if.upd_ready_o);
    end
  endtask

  task automatic test_init_sweep;
    rst_ni = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick;
      n_checks++;
      if (ghr_clear_o !== (k == 0)) begin
        n_fail++; $display("FAIL sweep_ghr k=%0d: got %b expected %b", k, ghr_clear_o, k == 0);
      end
      n_checks++;
      if ({pht_wr_en_o, pht_clear_o, pht_wr_index_o} !== {1'b1, 1'b1, 6'(k)}) begin
        n_fail++; $display("FAIL sweep_pht k=%0d: got en=%b clr=%b idx=%0d", k, pht_wr_en_o, pht_clear_o, pht_wr_index_o);
      end
      n_checks++;
      if (btb_wr_en_o !== (k < 16)) begin
        n_fail++; $display("FAIL sweep_btb_en k=%0d: got %b expected %b", k, btb_wr_en_o, k < 16);
      end
      if (k < 16) begin
        n_checks++;
        if ({btb_wr_index_o, btb_wr_valid_o, btb_wr_tag_o, btb_wr_target_o} !== {4'(k), 1'b0, 26'h0, 32'h0}) begin
          n_fail++; $display("FAIL sweep_btb_data k=%0d: got idx=%0d vld=%b tag=%h tgt=%h", k,
                             btb_wr_index_o, btb_wr_valid_o, btb_wr_tag_o, btb_wr_target_o);
        end
      end
      n_checks++;
      if ({flush_ack_o, pred_enable_o} !== {(k == 63), (k == 63)}) begin
        n_fail++; $display("FAIL sweep_ack k=%0d: got ack=%b pred=%b", k, flush_ack_o, pred_enable_o);
      end
    end
    tick;
    n_checks++;
    if ({flush_ack_o, pred_enable_o, btb_wr_en_o, pht_wr_en_o} !== 4'b0100) begin
      n_fail++; $display("FAIL sweep_after: got ack/pred/btb/pht=%b expected 0100",
                         {flush_ack_o, pred_enable_o, btb_wr_en_o, pht_wr_en_o});
    end
  endtask

  task automatic test_bypass;
    drive_upd(1'b1, 1'b1, 1'b1, 4'd5, 26'h1234, 32'h80, 6'h2A, 1'b1);
    n_checks++;
    if (upd_if.upd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bypass_ready: got %b expected 1", upd_if.upd_ready_o);
    end
    tick;
    upd_if.upd_valid_i = 1'b0;
    n_checks++;
    if ({btb_wr_en_o, btb_wr_valid_o, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !==
        {1'b1, 1'b1, 4'd5, 26'h1234, 32'h80}) begin
      n_fail++; $display("FAIL bypass_btb: got en=%b vld=%b idx=%0d tag=%h tgt=%h expected 1 1 5 1234 80",
                         btb_wr_en_o, btb_wr_valid_o, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o);
    end
    n_checks++;
    if ({pht_wr_en_o, pht_wr_index_o, pht_wr_taken_o, pht_clear_o} !== {1'b1, 6'h2A, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bypass_pht: got en=%b idx=%h tk=%b clr=%b expected 1 2a 1 0",
                         pht_wr_en_o, pht_wr_index_o, pht_wr_taken_o, pht_clear_o);
    end
    tick;
    n_checks++;
    if ({btb_wr_en_o, pht_wr_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL bypass_idle: got %b expected 00", {btb_wr_en_o, pht_wr_en_o});
    end
  endtask

  task automatic test_pht_only;
    drive_upd(1'b1, 1'b0, 1'b1, 4'd9, 26'h77, 32'h400, 6'h15, 1'b0);
    tick;
    upd_if.upd_valid_i = 1'b0;
    n_checks++;
    if ({btb_wr_en_o, pht_wr_en_o, pht_wr_index_o, pht_wr_taken_o} !== {1'b0, 1'b1, 6'h15, 1'b0}) begin
      n_fail++; $display("FAIL pht_only: got btb=%b pht=%b idx=%h tk=%b expected 0 1 15 0",
                         btb_wr_en_o, pht_wr_en_o, pht_wr_index_o, pht_wr_taken_o);
    end
    tick;
    n_checks++;
    if (pht_wr_en_o !== 1'b0) begin
      n_fail++; $display("FAIL pht_only_idle: got %b expected 0", pht_wr_en_o);
    end
  endtask

  task automatic test_back_to_back;
    int waited;
    logic got;
    flush_req_i = 1'b1;
    tick;
    flush_req_i = 1'b0;
    n_checks++;
    if ({pred_enable_o, pht_wr_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_flush_cycle: got pred/pht=%b expected 00", {pred_enable_o, pht_wr_en_o});
    end
    for (int i = 0; i < 6; i++) begin
      drive_upd(1'b1, 1'b1, 1'b1, 4'(i + 1), 26'(32'h100 + i), 32'h1000 + 32'(4 * i), 6'(32'h30 + i), i[0]);
      n_checks++;
      if (upd_if.upd_ready_o !== (i < 4)) begin
        n_fail++; $display("FAIL b2b_ready i=%0d: got %b expected %b", i, upd_if.upd_ready_o, i < 4);
      end
      tick;
    end
    upd_if.upd_valid_i = 1'b0;
    waited = 6;
    got = 1'b0;
    while (!got && waited < 80) begin
      if (flush_ack_o === 1'b1) got = 1'b1;
      else begin tick; waited++; end
    end
    n_checks++;
    if (!got || waited != 64) begin
      n_fail++; $display("FAIL b2b_ack_time: got seen=%b cycle=%0d expected seen=1 cycle=64", got, waited);
    end
    n_checks++;
    if (upd_if.upd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full_at_ack: got %b expected 0", upd_if.upd_ready_o);
    end
    for (int j = 0; j < 4; j++) begin
      tick;
      n_checks++;
      if ({btb_wr_en_o, btb_wr_valid_o, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !==
          {1'b1, 1'b1, 4'(j + 1), 26'(32'h100 + j), 32'h1000 + 32'(4 * j)}) begin
        n_fail++; $display("FAIL b2b_btb j=%0d: got en=%b vld=%b idx=%0d tag=%h tgt=%h", j,
                           btb_wr_en_o, btb_wr_valid_o, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o);
      end
      n_checks++;
      if ({pht_wr_en_o, pht_wr_index_o, pht_wr_taken_o, pht_clear_o} !== {1'b1, 6'(32'h30 + j), j[0], 1'b0}) begin
        n_fail++; $display("FAIL b2b_pht j=%0d: got en=%b idx=%h tk=%b clr=%b", j,
                           pht_wr_en_o, pht_wr_index_o, pht_wr_taken_o, pht_clear_o);
      end
      if (j == 0) begin
        n_checks++;
        if (upd_if.upd_ready_o !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready_after_pop: got %b expected 1", upd_if.upd_ready_o);
        end
      end
    end
    tick;
    n_checks++;
    if ({btb_wr_en_o, pht_wr_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_drained: got %b expected 00", {btb_wr_en_o, pht_wr_en_o});
    end
  endtask

  task automatic test_flush_mid_sweep;
    int ghr_n, ack_n, ghr_at, ack_at;
    flush_req_i = 1'b1;
    tick;
    flush_req_i = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      tick;
      n_checks++;
      if ({pht_wr_index_o, ghr_clear_o} !== {6'(k), (k == 0)}) begin
        n_fail++; $display("FAIL fm_sweep k=%0d: got idx=%0d ghr=%b", k, pht_wr_index_o, ghr_clear_o);
      end
    end
    flush_req_i = 1'b1;
    tick;
    flush_req_i = 1'b0;
    n_checks++;
    if ({pht_wr_en_o, ghr_clear_o, flush_ack_o} !== 3'b000) begin
      n_fail++; $display("FAIL fm_abort_cycle: got pht/ghr/ack=%b expected 000", {pht_wr_en_o, ghr_clear_o, flush_ack_o});
    end
    ghr_n = 0; ack_n = 0; ghr_at = 0; ack_at = 0;
    for (int t = 1; t <= 70; t++) begin
      tick;
      if (ghr_clear_o === 1'b1) begin ghr_n++; ghr_at = t; end
      if (flush_ack_o === 1'b1) begin ack_n++; ack_at = t; end
    end
    n_checks++;
    if (ghr_n != 1 || ghr_at != 1) begin
      n_fail++; $display("FAIL fm_ghr: got count=%0d at=%0d expected 1 at 1", ghr_n, ghr_at);
    end
    n_checks++;
    if (ack_n != 1 || ack_at != 64) begin
      n_fail++; $display("FAIL fm_ack: got count=%0d at=%0d expected 1 at 64", ack_n, ack_at);
    end
  endtask

  task automatic test_reset_mid_run;
    int waited;
    logic got;
    flush_req_i = 1'b1;
    tick;
    flush_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_upd(1'b1, 1'b1, 1'b1, 4'hE, 26'h3FF_FF00 + 26'(i), 32'hDEAD_0000, 6'h3E, 1'b1);
      tick;
    end
    upd_if.upd_valid_i = 1'b0;
    waited = 3;
    got = 1'b0;
    while (!got && waited < 80) begin
      if (flush_ack_o === 1'b1) got = 1'b1;
      else begin tick; waited++; end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL rr_ack_seen: got 0 expected 1");
    end
    rst_ni = 1'b0;
    tick;
    rst_ni = 1'b1;
    n_checks++;
    if ({btb_wr_en_o, pht_wr_en_o, ghr_clear_o, flush_ack_o, pred_enable_o} !== 5'b0) begin
      n_fail++; $display("FAIL rr_reset_outputs: got %b expected 00000",
                         {btb_wr_en_o, pht_wr_en_o, ghr_clear_o, flush_ack_o, pred_enable_o});
    end
    for (int k = 0; k < 64; k++) begin
      tick;
      n_checks++;
      if ({btb_wr_en_o & btb_wr_valid_o, pht_wr_en_o & ~pht_clear_o, flush_ack_o, pht_wr_index_o} !==
          {1'b0, 1'b0, (k == 63), 6'(k)}) begin
        n_fail++; $display("FAIL rr_sweep k=%0d: got btbvld=%b phtupd=%b ack=%b idx=%0d", k,
                           btb_wr_en_o & btb_wr_valid_o, pht_wr_en_o & ~pht_clear_o, flush_ack_o, pht_wr_index_o);
      end
    end
    for (int t = 0; t < 6; t++) begin
      tick;
      n_checks++;
      if ({btb_wr_en_o, pht_wr_en_o} !== 2'b00) begin
        n_fail++; $display("FAIL rr_no_stale t=%0d: got %b expected 00", t, {btb_wr_en_o, pht_wr_en_o});
      end
    end
  endtask

  initial begin
    test_reset;
    test_init_sweep;
    test_bypass;
    test_pht_only;
    test_back_to_back;
    test_flush_mid_sweep;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
